// File: rtl/spk_pkg.sv
// Shared definitions for the spike/data packet path: packet type codes,
// coordinate field layout and the encoder state encoding.
package spk_pkg;

    localparam logic [2:0] TYPE_SPIKE    = 3'b000;
    localparam logic [2:0] TYPE_DATA     = 3'b001;
    localparam logic [2:0] TYPE_DATA_END = 3'b010;
    localparam logic [2:0] TYPE_WRITE    = 3'b011;
    localparam logic [2:0] TYPE_READ     = 3'b100;

    // Payload is {z, y, x}, x in the LSBs, each field SW/3 bits wide.
    localparam int unsigned SW_DEF = 24;
    localparam int unsigned CW_DEF = SW_DEF / 3;
    localparam int unsigned X_LSB  = 0;
    localparam int unsigned Y_LSB  = CW_DEF;
    localparam int unsigned Z_LSB  = 2 * CW_DEF;

    function automatic int unsigned coord_w(input int unsigned sw);
        return sw / 3;
    endfunction

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DIVZ     = 3'd1;
    localparam logic [2:0] ST_DIVY     = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_RD_ISSUE = 3'd4;
    localparam logic [2:0] ST_RD_WAIT  = 3'd5;
    localparam logic [2:0] ST_RD_SEND  = 3'd6;

endpackage

// File: rtl/nn_div.sv
// Restoring shift-subtract divider with a fixed NNW-cycle latency.
// A zero divisor naturally yields quotient all-ones and remainder = dividend.
module nn_div #(
    parameter int unsigned NNW = 12
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [NNW-1:0] dividend_i,
    input  logic [NNW-1:0] divisor_i,
    output logic           done_o,
    output logic [NNW-1:0] quot_o,
    output logic [NNW-1:0] rem_o
);

    localparam int unsigned CNTW = $clog2(NNW + 1);

    logic [NNW-1:0]  q_q;
    logic [NNW-1:0]  r_q;
    logic [NNW-1:0]  d_q;
    logic [CNTW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;

    logic [NNW:0]    trial;
    logic [NNW:0]    diff;
    logic [NNW-1:0]  r_d;
    logic            qbit;

    // q_q starts as the dividend and shifts quotient bits in from the LSB.
    always_comb begin
        trial = {r_q, q_q[NNW-1]};
        diff  = trial - {1'b0, d_q};
        qbit  = 1'b0;
        r_d   = trial[NNW-1:0];
        if (trial >= {1'b0, d_q}) begin
            qbit = 1'b1;
            r_d  = diff[NNW-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                q_q    <= dividend_i;
                r_q    <= '0;
                d_q    <= divisor_i;
                cnt_q  <= CNTW'(NNW);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                q_q   <= {q_q[NNW-2:0], qbit};
                r_q   <= r_d;
                cnt_q <= cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign quot_o = q_q;
    assign rem_o  = r_q;

endmodule

// File: rtl/spk_out_encoder.sv
// Transmit-side encoder: turns fired-neuron indices into global SPIKE packets
// and serves soma memory readouts as DATA ... DATA_END packet trains.
module spk_out_encoder
    import spk_pkg::*;
#(
    parameter int unsigned NNW = 12,
    parameter int unsigned SW  = 24,
    parameter int unsigned FTW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soma_spk_vld,
    input  logic [NNW-1:0]    soma_spk_addr,
    output logic              spk_rdy,
    input  logic              rd_req,
    input  logic [NNW-1:0]    rd_len,
    output logic              rd_ack,
    output logic              rd_en,
    output logic [NNW-1:0]    rd_addr,
    input  logic [SW-1:0]     rd_data,
    input  logic [NNW-1:0]    x_out,
    input  logic [NNW-1:0]    xy_out,
    input  logic [SW/3-1:0]   x_start,
    input  logic [SW/3-1:0]   y_start,
    output logic              spk_out_vld,
    output logic [SW-1:0]     spk_out_data,
    output logic [FTW-1:0]    spk_out_type,
    input  logic              spk_out_busy
);

    localparam int unsigned CW = coord_w(SW);

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  z_q, z_d;
    logic [SW-1:0]  pkt_q, pkt_d;
    logic [FTW-1:0] type_q, type_d;
    logic [NNW-1:0] cnt_q, cnt_d;
    logic [NNW-1:0] len_q, len_d;
    logic           ack_q, ack_d;

    logic           div_start;
    logic           div_done;
    logic [NNW-1:0] div_dividend;
    logic [NNW-1:0] div_divisor;
    logic [NNW-1:0] div_quot;
    logic [NNW-1:0] div_rem;

    logic [CW-1:0]  y_g;
    logic [CW-1:0]  x_g;
    logic           last_word;

    // One divider serves both stages: n/xy_out from IDLE, then rem/x_out
    // chained straight off the first result.
    assign div_start    = ((state_q == ST_IDLE) && soma_spk_vld) ||
                          ((state_q == ST_DIVZ) && div_done);
    assign div_dividend = (state_q == ST_IDLE) ? soma_spk_addr : div_rem;
    assign div_divisor  = (state_q == ST_IDLE) ? xy_out : x_out;

    nn_div #(
        .NNW (NNW)
    ) u_div (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    assign y_g       = CW'(div_quot) + y_start;
    assign x_g       = CW'(div_rem) + x_start;
    assign last_word = (cnt_q == len_q - NNW'(1));

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        pkt_d   = pkt_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (soma_spk_vld) begin
                    state_d = ST_DIVZ;
                end else if (rd_req) begin
                    len_d   = (rd_len < NNW'(2)) ? NNW'(2) : rd_len;
                    cnt_d   = '0;
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_DIVZ: begin
                if (div_done) begin
                    z_d     = CW'(div_quot);
                    state_d = ST_DIVY;
                end
            end
            ST_DIVY: begin
                if (div_done) begin
                    pkt_d   = SW'({z_q, y_g, x_g});
                    type_d  = FTW'(TYPE_SPIKE);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!spk_out_busy) state_d = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                pkt_d   = rd_data;
                type_d  = last_word ? FTW'(TYPE_DATA_END) : FTW'(TYPE_DATA);
                state_d = ST_RD_SEND;
            end
            ST_RD_SEND: begin
                if (!spk_out_busy) begin
                    if (last_word) begin
                        ack_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + NNW'(1);
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            z_q     <= '0;
            pkt_q   <= '0;
            type_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            pkt_q   <= pkt_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ack_q   <= ack_d;
        end
    end

    // spk_rdy is gated by rst so every output reads 0 while reset is held.
    assign spk_rdy      = (state_q == ST_IDLE) && !rst;
    assign spk_out_vld  = (state_q == ST_SEND) || (state_q == ST_RD_SEND);
    assign spk_out_data = pkt_q;
    assign spk_out_type = type_q;
    assign rd_en        = (state_q == ST_RD_ISSUE);
    assign rd_addr      = cnt_q;
    assign rd_ack       = ack_q;

endmodule

// File: doc/spk_out_encoder.md
Name: spk_out_encoder

Overview:
Transmit-side counterpart of the node's spike/data input path.
- Converts a fired neuron's linear index from soma into a global (x,y,z) SPIKE packet.
- Serves block readout requests by reading soma memory and emitting a DATA…DATA_END packet train toward the router.
- Packet format, type codes and coordinate layout match what the node's input side decodes.

Parameters:
NNW, 12, neuron/local index width
SW, 24, packet payload width; three SW/3 coordinate fields {z,y,x}, x in LSBs
FTW, 3, packet type width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
soma_spk_vld  in  1  fired-neuron request
soma_spk_addr  in  NNW  linear neuron index n = z*xy_out + y*x_out + x
spk_rdy  out  1  encoder can accept a spike (high only in IDLE)
rd_req  in  1  readout request, level, sampled in IDLE
rd_len  in  NNW  words to read
rd_ack  out  1  one-cycle pulse when readout train completes
rd_en  out  1  soma memory read strobe
rd_addr  out  NNW  soma memory read address
rd_data  in  SW  read data, valid the cycle after rd_en
x_out  in  NNW  output map width
xy_out  in  NNW  x_out*y_out
x_start  in  SW/3  global x offset of this node's tile
y_start  in  SW/3  global y offset
spk_out_vld  out  1  packet valid
spk_out_data  out  SW  packet payload
spk_out_type  out  FTW  SPIKE=000, DATA=001, DATA_END=010
spk_out_busy  in  1  router stall; packet consumed on an edge where vld=1 and busy=0

Behaviour:
- Reset: all outputs 0; state IDLE. rst mid-operation aborts any division or train; spk_out_vld=0 the cycle after rst. No rd_ack is issued for an aborted train.
- States: IDLE, DIVZ, DIVY, SEND, RD_ISSUE, RD_WAIT, RD_SEND.
- IDLE:
  - spk_rdy=1.
  - If soma_spk_vld, latch addr and go to DIVZ. Spike wins over a simultaneous rd_req.
  - Else if rd_req, latch len (values <2 forced to 2; input side requires DATA then DATA_END), clear word counter, go to RD_ISSUE.
- DIVZ: n / xy_out → z, rem. DIVY: rem / x_out → y, x.
  - Each division is restoring shift-subtract, exactly NNW cycles.
  - Divisor 0 yields quotient all-ones, remainder = dividend (no hang).
- Packet assembly:
  - x_g = x + x_start, y_g = y + y_start, both truncated mod 2^(SW/3).
  - z truncated to SW/3.
  - data = {z, y_g, x_g}, type = SPIKE.
- Spike latency: spk_out_vld first high exactly 2*NNW+2 cycles after the accepting edge.
- SEND:
  - vld, data and type are held stable while busy=1.
  - On the consuming edge go to IDLE; vld=0 next cycle.
- Readout:
  - RD_ISSUE: rd_en=1 for one cycle, rd_addr = word counter (starts at 0).
  - RD_WAIT: capture rd_data.
  - RD_SEND: present packet; type DATA, or DATA_END on the last word (counter = len-1).
  - On consume: if not last, counter+1 and return to RD_ISSUE. If last, rd_ack=1 for one cycle and go to IDLE.
- soma_spk_vld and rd_req are ignored outside IDLE; the requester holds them.
- Counters wrap mod 2^NNW. No other wrap handling is required.

Decomposition:
- Shared package spk_pkg:
  - type codes SPIKE/DATA/DATA_END/WRITE/READ;
  - coordinate field slice constants from SW;
  - state encoding.
- One sub-module, nn_div: NNW-bit restoring divider.
  - Interface: start, dividend, divisor → done, quot, rem.
  - Fixed NNW-cycle latency.
  - Instantiated once and reused for both DIVZ and DIVY.

Test Plan:
- Spike decode: x_out=4, xy_out=16, x_start=8, y_start=0, addr=37 → after 26 cycles vld=1, type=000, data=0x020109.
- Backpressure: same spike, busy=1 for 3 cycles → vld/data stable for 3 cycles; packet consumed on 4th edge; spk_rdy returns next cycle.
- Readout: rd_len=3, memory word i = 0x0A0000+i → rd_addr 0,1,2; packets 0x0A0000 DATA, 0x0A0001 DATA, 0x0A0002 DATA_END; one rd_ack pulse.
- Priority and short length: soma_spk_vld and rd_req asserted together with rd_len=1 → SPIKE packet first; then two packets, DATA then DATA_END.
- Corner: x_out=0 → completes in 26 cycles, no hang; addr=0 with starts=0 → data=0.
- Reset mid-train: rst asserted during RD_SEND with busy=1 → vld=0 next cycle, state IDLE, no rd_ack.
